// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared constants, types and speed stepping for the LED pattern engine
package led_pattern_pkg;

  // Speed index: 0 is the slowest, each step halves the tick period
  localparam int SPEED_W = 3;
  localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;

  // Pattern modes as selected by sw[1:0]
  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_BOUNCE  = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_ROTATE  = 2'd3
  } mode_e;

  // Travel direction for bounce position and breathe duty
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Saturating speed step; simultaneous up and down presses cancel out
  function automatic logic [SPEED_W-1:0] next_speed(input logic [SPEED_W-1:0] cur,
                                                    input logic up,
                                                    input logic down);
    next_speed = cur;
    if (up && !down && (cur != SPEED_MAX)) begin
      next_speed = cur + SPEED_W'(1);
    end else if (down && !up && (cur != '0)) begin
      next_speed = cur - SPEED_W'(1);
    end
  endfunction

endpackage

// File: rtl/led_pattern_gen_key_debounce.sv
// rtl/led_pattern_gen_key_debounce.sv - push-button synchroniser, debouncer and press pulse
module key_debounce
  import led_pattern_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Two-flop synchroniser for the asynchronous button pin
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= key_ni;
      sync_q <= meta_q;
    end
  end

  // Count consecutive samples that disagree with the accepted level; a new
  // level is taken on the DEBOUNCE_CYCLES-th one, and a released-to-pressed
  // acceptance emits the press pulse
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync_q;
      cnt_d   = '0;
      press_d = level_q & ~sync_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state; the accepted level starts as released
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - selectable-mode LED pattern engine with key-stepped speed
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS        = 8,
  parameter int PRESCALE_W      = 20,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PWM_W           = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          key_n,
  input  logic [3:0]          sw,
  output logic [NUM_LEDS-1:0] led,
  output logic [SPEED_W-1:0]  speed,
  output logic [1:0]          mode,
  output logic                tick
);

  localparam int POS_W = $clog2(NUM_LEDS);
  localparam logic [POS_W-1:0]    POS_MAX  = POS_W'(NUM_LEDS - 1);
  localparam logic [PWM_W-1:0]    DUTY_MAX = '1;
  localparam logic [NUM_LEDS-1:0] ROT_INIT = NUM_LEDS'(1);

  // Switch path
  logic [3:0] sw_meta_q;
  logic [3:0] sw_sync_q;
  logic [3:0] sw_q;
  mode_e      mode_q;
  logic       pause;
  logic       reverse;
  logic       mode_chg;

  // Speed and timebase
  logic [1:0]            press;
  logic [SPEED_W-1:0]    speed_q;
  logic [SPEED_W-1:0]    speed_d;
  logic                  speed_chg;
  logic [PRESCALE_W-1:0] presc_q;
  logic [PRESCALE_W-1:0] presc_d;
  logic [PRESCALE_W-1:0] presc_limit;
  logic                  adv;
  logic                  tick_q;

  // Pattern state
  logic [NUM_LEDS-1:0] count_q, count_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  dir_e                bdir_q, bdir_d;
  logic [PWM_W-1:0]    duty_q, duty_d;
  dir_e                ddir_q, ddir_d;
  logic [NUM_LEDS-1:0] rot_q, rot_d;
  logic [PWM_W-1:0]    pwm_q;
  logic [NUM_LEDS-1:0] led_q, led_d;

  // Switches: two-flop synchroniser, then the working register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      sw_q      <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      sw_q      <= sw_sync_q;
    end
  end

  assign mode_q  = mode_e'(sw_q[1:0]);
  assign pause   = sw_q[2];
  assign reverse = sw_q[3];
  // True in the cycle the working register is about to take a new mode
  assign mode_chg = (sw_sync_q[1:0] != sw_q[1:0]);

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .key_ni  (key_n[0]),
    .press_o (press[0])
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_down (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .key_ni  (key_n[1]),
    .press_o (press[1])
  );

  // Speed next-state and the prescaler terminal count it selects
  always_comb begin
    speed_d     = next_speed(speed_q, press[0], press[1]);
    speed_chg   = (speed_d != speed_q);
    presc_limit = {PRESCALE_W{1'b1}} >> speed_q;
    adv         = !pause && !mode_chg && !speed_chg && (presc_q == presc_limit);
  end

  // Prescaler: restarts on mode or speed change, holds while paused
  always_comb begin
    presc_d = presc_q;
    if (mode_chg || speed_chg) begin
      presc_d = '0;
    end else if (!pause) begin
      presc_d = (presc_q == presc_limit) ? '0 : presc_q + PRESCALE_W'(1);
    end
  end

  // Timebase registers: speed, prescaler, tick pulse and free-running PWM counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      speed_q <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      pwm_q   <= '0;
    end else begin
      speed_q <= speed_d;
      presc_q <= presc_d;
      tick_q  <= adv;
      pwm_q   <= pwm_q + PWM_W'(1);
    end
  end

  // Pattern next-state: reinitialise on mode change, otherwise step the active mode on a tick
  always_comb begin
    count_d = count_q;
    pos_d   = pos_q;
    bdir_d  = bdir_q;
    duty_d  = duty_q;
    ddir_d  = ddir_q;
    rot_d   = rot_q;
    if (mode_chg) begin
      count_d = '0;
      pos_d   = '0;
      bdir_d  = DIR_UP;
      duty_d  = '0;
      ddir_d  = DIR_UP;
      rot_d   = ROT_INIT;
    end else if (adv) begin
      case (mode_q)
        MODE_COUNT: begin
          count_d = count_q + NUM_LEDS'(1);
        end
        MODE_BOUNCE: begin
          // Turn around at each end without repeating the end position
          if (bdir_q == DIR_UP) begin
            if (pos_q == POS_MAX) begin
              pos_d  = pos_q - POS_W'(1);
              bdir_d = DIR_DOWN;
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end else begin
            if (pos_q == '0) begin
              pos_d  = POS_W'(1);
              bdir_d = DIR_UP;
            end else begin
              pos_d = pos_q - POS_W'(1);
            end
          end
        end
        MODE_BREATHE: begin
          if (ddir_q == DIR_UP) begin
            if (duty_q == DUTY_MAX) begin
              duty_d = duty_q - PWM_W'(1);
              ddir_d = DIR_DOWN;
            end else begin
              duty_d = duty_q + PWM_W'(1);
            end
          end else begin
            if (duty_q == '0) begin
              duty_d = PWM_W'(1);
              ddir_d = DIR_UP;
            end else begin
              duty_d = duty_q - PWM_W'(1);
            end
          end
        end
        MODE_ROTATE: begin
          rot_d = reverse ? {rot_q[0], rot_q[NUM_LEDS-1:1]}
                          : {rot_q[NUM_LEDS-2:0], rot_q[NUM_LEDS-1]};
        end
      endcase
    end
  end

  // Pattern state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      pos_q   <= '0;
      bdir_q  <= DIR_UP;
      duty_q  <= '0;
      ddir_q  <= DIR_UP;
      rot_q   <= ROT_INIT;
    end else begin
      count_q <= count_d;
      pos_q   <= pos_d;
      bdir_q  <= bdir_d;
      duty_q  <= duty_d;
      ddir_q  <= ddir_d;
      rot_q   <= rot_d;
    end
  end

  // LED image of the current state; breathe keeps tracking the PWM compare even when paused
  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_COUNT:   led_d = count_q;
      MODE_BOUNCE:  led_d = ROT_INIT << pos_q;
      MODE_BREATHE: led_d = {NUM_LEDS{(pwm_q < duty_q)}};
      MODE_ROTATE:  led_d = rot_q;
    endcase
  end

  // Registered LED output, one cycle behind the pattern state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led   = led_q;
  assign speed = speed_q;
  assign mode  = sw_q[1:0];
  assign tick  = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - directed self-checking bench for led_pattern_gen
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] key_n = 2'b11;
  logic [3:0] sw = 4'h0;
  logic [7:0] led;
  logic [2:0] speed;
  logic [1:0] mode;
  logic       tick;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .NUM_LEDS(8), .PRESCALE_W(10), .DEBOUNCE_CYCLES(16), .PWM_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_n(key_n), .sw(sw),
    .led(led), .speed(speed), .mode(mode), .tick(tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the falling edge where tick is high; n = cycles waited
  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < limit);
    chk("tick_seen", 32'(tick), 32'd1);
  endtask

  task automatic press_key(input logic [1:0] which);
    key_n = ~which;
    step(30);
    key_n = 2'b11;
    step(30);
  endtask

  // Duty is frozen by pause; count cycles with all LEDs lit over one PWM period
  task automatic duty_window(input string tag, input int exp);
    int hi;
    int bad;
    hi = 0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led == 8'hFF) hi++;
      else if (led != 8'h00) bad++;
    end
    chk(tag, 32'(hi), 32'(exp));
    chk({tag, "_uniform"}, 32'(bad), 32'd0);
  endtask

  logic [7:0] bexp [15];
  logic [7:0] rexp [9];

  initial begin
    int n;
    int ticks;
    int chg;
    bexp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
             8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    rexp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};

    // Reset state
    step(3);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_speed", 32'(speed), 32'h0);
    chk("rst_mode", 32'(mode), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);

    // COUNT at speed 0: first tick one full period after release
    reset_n = 1'b1;
    wait_tick(2000, n);
    chk("first_tick_cycles", 32'(n), 32'd1024);
    chk("led_before_update", 32'(led), 32'h00);
    step(1);
    chk("count_led1", 32'(led), 32'h01);
    chk("tick_pulse_width", 32'(tick), 32'h0);
    wait_tick(2000, n);
    chk("period_speed0", 32'(n), 32'd1023);
    step(1);
    chk("count_led2", 32'(led), 32'h02);

    // Keys: three presses, glitch, saturation
    for (int i = 0; i < 3; i++) press_key(2'b01);
    chk("speed_3", 32'(speed), 32'd3);
    wait_tick(2000, n);
    wait_tick(2000, n);
    chk("period_speed3", 32'(n), 32'd128);
    key_n = 2'b10;
    step(10);
    key_n = 2'b11;
    step(30);
    chk("glitch_ignored", 32'(speed), 32'd3);
    for (int i = 0; i < 9; i++) press_key(2'b01);
    chk("speed_sat_7", 32'(speed), 32'd7);
    wait_tick(2000, n);
    wait_tick(2000, n);
    chk("period_speed7", 32'(n), 32'd8);

    // COUNT wrap from a freshly reinitialised count
    sw = 4'h1;
    step(6);
    sw = 4'h0;
    step(6);
    for (int i = 0; i < 255; i++) wait_tick(100, n);
    step(1);
    chk("count_ff", 32'(led), 32'hFF);
    wait_tick(100, n);
    step(1);
    chk("count_wrap", 32'(led), 32'h00);

    // BOUNCE with mid-sequence pause
    sw = 4'h1;
    step(2);
    chk("mode_latency_2", 32'(mode), 32'd0);
    step(1);
    chk("mode_latency_3", 32'(mode), 32'd1);
    step(1);
    chk("bounce_init", 32'(led), 32'h01);
    for (int i = 0; i < 5; i++) begin
      wait_tick(100, n);
      step(1);
      chk($sformatf("bounce_%0d", i), 32'(led), 32'(bexp[i]));
    end
    sw = 4'h5;
    ticks = 0;
    chg = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (tick) ticks++;
      if (led !== 8'h20) chg++;
    end
    chk("pause_ticks", 32'(ticks), 32'd0);
    chk("pause_led_moves", 32'(chg), 32'd0);
    sw = 4'h1;
    for (int i = 5; i < 15; i++) begin
      wait_tick(100, n);
      step(1);
      chk($sformatf("bounce_%0d", i), 32'(led), 32'(bexp[i]));
    end

    // BREATHE at speed 7
    sw = 4'h2;
    step(5);
    chk("breathe_mode", 32'(mode), 32'd2);
    chk("breathe_duty0_off", 32'(led), 32'h00);
    for (int i = 0; i < 64; i++) wait_tick(100, n);
    sw = 4'h6;
    step(5);
    duty_window("duty_64", 64);
    sw = 4'h2;
    for (int i = 0; i < 191; i++) wait_tick(100, n);
    sw = 4'h6;
    step(5);
    duty_window("duty_255", 255);
    sw = 4'h2;
    wait_tick(100, n);
    sw = 4'h6;
    step(5);
    duty_window("duty_254", 254);

    // Simultaneous presses cancel; down-key saturates at 0
    for (int i = 0; i < 3; i++) press_key(2'b10);
    chk("speed_4", 32'(speed), 32'd4);
    press_key(2'b11);
    chk("both_keys", 32'(speed), 32'd4);
    for (int i = 0; i < 6; i++) press_key(2'b10);
    chk("speed_sat_0", 32'(speed), 32'd0);
    press_key(2'b01);
    press_key(2'b01);
    chk("speed_2", 32'(speed), 32'd2);

    // ROTATE left, then reversed by sw[3]
    sw = 4'h3;
    step(4);
    chk("rotate_mode", 32'(mode), 32'd3);
    chk("rotate_init", 32'(led), 32'h01);
    for (int i = 0; i < 9; i++) begin
      wait_tick(400, n);
      step(1);
      chk($sformatf("rotate_%0d", i), 32'(led), 32'(rexp[i]));
      if (i == 6) sw = 4'hB;
    end

    // Asynchronous reset mid-rotation
    step(10);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(led), 32'h0);
    chk("async_rst_speed", 32'(speed), 32'h0);
    chk("async_rst_mode", 32'(mode), 32'h0);
    chk("async_rst_tick", 32'(tick), 32'h0);
    step(2);
    reset_n = 1'b1;
    step(5);
    chk("post_rst_mode", 32'(mode), 32'd3);
    chk("post_rst_rot", 32'(led), 32'h01);
    wait_tick(2000, n);
    step(1);
    chk("post_rst_rot_right", 32'(led), 32'h80);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern engine for the DE10-Nano fabric LEDs. It replaces the free-running LED counter with a selectable-mode generator: binary count, bounce, PWM breathe and rotate. Mode, pause and direction come from synchronised SW inputs. Speed is stepped by debounced KEY presses. It sits in the top level between the board pins (KEY, SW, LED) and the 50 MHz fabric clock.

Parameters:
NUM_LEDS, 8, number of LED outputs (must be ≥2)
PRESCALE_W, 20, prescaler width; at speed 0 the tick period is 2^PRESCALE_W cycles (must be ≥8)
DEBOUNCE_CYCLES, 1000000, number of consecutive stable cycles before a key level is accepted
PWM_W, 8, width of the breathe duty and PWM counter

Ports:
clk  input  1  fabric clock, 50 MHz; all logic on the rising edge
reset_n  input  1  asynchronous, active-low reset
key_n  input  2  raw push buttons, active-low, asynchronous; [0] speeds up, [1] slows down
sw  input  4  raw switches, asynchronous; [1:0] mode, [2] pause, [3] reverse direction for rotate
led  output  NUM_LEDS  pattern output, registered
speed  output  3  current speed index 0..7
mode  output  2  current registered mode
tick  output  1  one-cycle pulse on each pattern step

Behaviour:
- Reset: one clock, asynchronous active-low reset (reset_n). While reset_n is low, every register clears immediately:
  - led=0, speed=0, mode=0, tick=0
  - prescaler=0, count=0, pos=0, bounce dir=up, duty=0, breathe dir=up
  - rotate reg = 1 (only bit 0 set)
  - synchronisers cleared; the debounced key level is initialised to released (1)
- SW inputs pass through a 2-flop synchroniser, then a register. A change on sw reaches the mode output 3 cycles later.
- Mode change: in the cycle the registered mode changes, the new mode's state is reinitialised to its reset values and the prescaler clears. The first tick occurs a full period later.
- Prescaler:
  - increments every cycle unless pause=1, in which case it holds and no ticks occur
  - tick=1 for one cycle when prescaler == 2^(PRESCALE_W−speed)−1; prescaler then wraps to 0
  - a speed change clears the prescaler in the same cycle
- Modes (state advances only on tick; led is registered one cycle after the state update):
  - 0 COUNT: count is NUM_LEDS bits and increments, wrapping from all-ones to 0; led=count.
  - 1 BOUNCE: led=one-hot(pos). pos moves 0→NUM_LEDS−1, then reverses at each end, so the ends are not repeated (…N−2, N−1, N−2…).
  - 2 BREATHE:
    - duty steps ±1 per tick; direction flips at 2^PWM_W−1 and at 0
    - a free-running PWM_W-bit PWM counter runs every cycle, independent of pause
    - led = all bits equal (pwm_cnt < duty); duty=0 gives all LEDs off
  - 3 ROTATE: rotate reg rotates left by one bit per tick, or right when sw[3]=1; led=rotate reg. sw[3] takes effect at the next tick.
- Keys:
  - each key passes through a 2-flop synchroniser, then a debouncer
  - the debouncer accepts a new level after DEBOUNCE_CYCLES consecutive identical samples; any differing sample restarts the count
  - a press event is a debounced 1→0 transition, one-cycle pulse
  - key[0] press: speed+1, saturating at 7; key[1] press: speed−1, saturating at 0
  - press events on both keys in the same cycle leave speed unchanged
  - speed updates the cycle after the event
- Pause: all pattern state and led hold, except in BREATHE, where led continues following the PWM compare against the held duty.

Decomposition:
- Package led_pattern_pkg holds:
  - mode constants MODE_COUNT=0, MODE_BOUNCE=1, MODE_BREATHE=2, MODE_ROTATE=3
  - SPEED_MAX=7
  - speed index width 3
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES), instantiated twice. It contains the synchroniser, stability counter and falling-edge pulse output press.

Test Plan:
(Bench overrides PRESCALE_W=10, DEBOUNCE_CYCLES=16.)
1. Reset release, sw=0 → first tick 1024 cycles after reset release; led=0x01 one cycle later; 0xFF → 0x00 wrap after 256 ticks.
2. sw=1 (bounce) → led sequence 01,02,…,80,40,…,01,02; pause (sw[2]=1) mid-sequence → led and tick frozen for 5000 cycles, resumes from the same position.
3. Key[0] held low 16 cycles, three separate presses → speed=3 and tick period 128 cycles; a glitch lasting 10 cycles → no speed change; 9 presses → speed saturates at 7, period 8 cycles.
4. Key[1] and key[0] pressed together from speed=4 → speed stays 4; key[1] ×6 → speed=0.
5. sw=2 (breathe), speed=7 → duty climbs to 255 after 255 ticks, then falls; when duty=64, led high for exactly 64 of every 256 cycles.
6. sw=3 → led 01,02,04…; set sw[3]=1 → 80→40 direction reversal; assert reset_n low mid-rotation → all outputs 0 immediately and asynchronously, rotate reg=1 after release.
